// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider, N in 2..2^WIDTH-1.
// Provides a period-start tick, divisor load/ack/err handshake applied at period
// boundaries, and a glitch-free run/park enable.
// Build option: define CLK_DIV_ODD_EN to add a negedge stage that gives odd N a
// 50% duty cycle. Without it the block is single-edge and odd N is high for one
// extra cycle.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic [WIDTH-1:0] cur_div,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             running_q, running_d;
  logic             pos_q, pos_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             load_ok, boundary;
  logic [WIDTH-1:0] hi_len;

  // Next-state: counter, pending divisor, boundary adoption, run/park, high phase.
  always_comb begin
    load_ok    = div_load && (div_val >= TWO);
    err_d      = div_load && !load_ok;
    // A parked divider is permanently at a boundary, so loads and enable take
    // effect on the very next edge.
    boundary   = !running_q || (cnt_q == cur_div_q - ONE);
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cur_div_d  = cur_div_q;
    ack_d      = 1'b0;
    running_d  = running_q;
    cnt_d      = cnt_q + ONE;
    // Last load wins; a load landing on the boundary cycle is applied there.
    if (load_ok) begin
      pend_d     = div_val;
      pend_vld_d = 1'b1;
    end
    if (boundary) begin
      cnt_d     = '0;
      running_d = enable;
      if (pend_vld_d) begin
        cur_div_d  = pend_d;
        pend_vld_d = 1'b0;
        ack_d      = 1'b1;
      end
    end
    // High length is ceil(N/2); written without N+1 so N = 2^WIDTH-1 fits.
    hi_len = (cur_div_d >> 1) + {{(WIDTH-1){1'b0}}, cur_div_d[0]};
    pos_d  = running_d && (cnt_d < hi_len);
  end

  // Posedge state; reset parks the divider and drops clk_out immediately.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      cur_div_q  <= DEF_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      running_q  <= 1'b0;
      pos_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      running_q  <= running_d;
      pos_q      <= pos_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

`ifdef CLK_DIV_ODD_EN
  logic neg_q, neg_d;

  // Half-cycle delayed copy of the high phase, used to trim odd N to 50%.
  always_comb neg_d = pos_q;

  // Negedge stage; it is always 0 at a period boundary, so switching the
  // odd/even select there cannot glitch clk_out.
  always_ff @(negedge clk_in or negedge reset) begin
    if (!reset) neg_q <= 1'b0;
    else        neg_q <= neg_d;
  end

  assign clk_out = cur_div_q[0] ? (pos_q & neg_q) : pos_q;
`else
  assign clk_out = pos_q;
`endif

  assign tick    = running_q && (cnt_q == '0);
  assign div_ack = ack_q;
  assign div_err = err_q;
  assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus pushes expected periods, acks and
// errors; a monitor pops them whenever tick/div_ack/div_err appear.
module tb_clk_div_prog;
  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         reset, enable, div_load;
  logic [W-1:0] div_val;
  logic         div_ack, div_err, tick, clk_out;
  logic [W-1:0] cur_div;

  clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(16)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .div_val(div_val),
    .div_load(div_load), .div_ack(div_ack), .div_err(div_err),
    .cur_div(cur_div), .tick(tick), .clk_out(clk_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {int div; int gap;} per_t;
  typedef struct {int div; int tk;}  ack_t;
  typedef struct {int cyc; int div;} err_t;
  per_t per_q[$];
  ack_t ack_q[$];
  err_t err_q[$];

  per_t cur;
  bit   have_cur = 0;
  bit   prev_co  = 0;
  int   hi_h = 0, rises = 0, last_tick = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // clk_out high time in half-cycles over one period.
  function automatic int hi_exp(input int n);
`ifdef CLK_DIV_ODD_EN
    return n;
`else
    return n + (n % 2);
`endif
  endfunction

  function automatic void push_per(input int d, input int g);
    per_t p;
    p.div = d; p.gap = g;
    per_q.push_back(p);
  endfunction

  function automatic void push_ack(input int d, input int t);
    ack_t a;
    a.div = d; a.tk = t;
    ack_q.push_back(a);
  endfunction

  function automatic void push_err(input int c, input int d);
    err_t e;
    e.cyc = c; e.div = d;
    err_q.push_back(e);
  endfunction

  task automatic sample(input bit first);
    ack_t a;
    err_t e;
    if (reset !== 1'b1) begin
      have_cur = 0; hi_h = 0; rises = 0; prev_co = 0;
      return;
    end
    if (first) begin
      if (tick === 1'b1) begin
        if (have_cur) begin
          if (cur.gap != 0) chk("tick_gap", cyc - last_tick, cur.gap);
          chk("hi_halves", hi_h, hi_exp(cur.div));
          chk("rises_per_period", rises, 1);
        end
        if (per_q.size() == 0) begin
          tests++; fails++; have_cur = 0;
          $display("FAIL tick_extra: got tick at cycle %0d want none", cyc);
        end else begin
          cur = per_q.pop_front();
          have_cur = 1;
          chk("tick_cur_div", int'(cur_div), cur.div);
        end
        last_tick = cyc; hi_h = 0; rises = 0;
      end
      if (div_ack === 1'b1) begin
        if (ack_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL ack_extra: got ack at cycle %0d want none", cyc);
        end else begin
          a = ack_q.pop_front();
          chk("ack_cur_div", int'(cur_div), a.div);
          chk("ack_with_tick", int'(tick), a.tk);
        end
      end
      if (div_err === 1'b1) begin
        if (err_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL err_extra: got err at cycle %0d want none", cyc);
        end else begin
          e = err_q.pop_front();
          chk("err_cycle", cyc, e.cyc);
          chk("err_cur_div", int'(cur_div), e.div);
        end
      end
    end
    if (clk_out === 1'b1) hi_h++;
    if (clk_out === 1'b1 && !prev_co) rises++;
    prev_co = (clk_out === 1'b1);
  endtask

  // Monitor: samples each half cycle, 2 time units after the edge.
  initial forever begin
    @(posedge clk_in); #2; sample(1'b1);
    @(negedge clk_in); #2; sample(1'b0);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic load(input int v);
    div_val  = W'(v);
    div_load = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; div_load = 1'b0; div_val = '0;
    #1 reset = 1'b0;
    #2;
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_ack", int'(div_ack), 0);
    chk("rst_err", int'(div_err), 0);
    chk("rst_cur_div", int'(cur_div), 16);

    // Expected sequence of periods (div, cycles to next tick; 0 = unchecked).
    push_per(16, 16); push_per(16, 16);
    push_per(5, 5);   push_per(5, 5);
    push_per(10, 10);
    push_per(8, 8);   push_per(8, 8);  push_per(8, 16);
    push_per(6, 6);
    push_per(255, 255); push_per(255, 0);
    push_ack(5, 1); push_ack(10, 1); push_ack(8, 1); push_ack(6, 0); push_ack(255, 1);

    @(posedge clk_in); #1;
    reset = 1'b1; enable = 1'b1;
    cycles(1);                       // T0: first tick, cnt 0
    cycles(20); load(5);             // T0+20: mid-period load of odd N
    cycles(1);  div_load = 1'b0;
    cycles(16); load(6);             // T0+37: two loads in one period
    cycles(1);  load(10);
    cycles(1);  div_load = 1'b0;
    cycles(6);  load(1);  push_err(cyc + 1, 10);   // rejected divisors
    cycles(1);  load(0);  push_err(cyc + 1, 10);
    cycles(1);  div_load = 1'b0;
    cycles(1);  load(8);             // T0+48
    cycles(1);  div_load = 1'b0;
    cycles(22); enable = 1'b0;       // T0+71: cnt 3 of an N=8 period
    cycles(7);  load(6);             // T0+78: load while parked
    cycles(1);  div_load = 1'b0;
    cycles(4);  enable = 1'b1;       // T0+83: restart
    cycles(2);  load(255);           // T0+85: maximum divisor
    cycles(1);  div_load = 1'b0;
    cycles(259); cycles(1); load(255); // T0+346: pending 255 again
    cycles(1);  div_load = 1'b0;     // T0+347: cnt 2
    chk("pre_rst_clk_out", int'(clk_out), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_clk_out", int'(clk_out), 0);
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_cur_div", int'(cur_div), 16);
    chk("async_rst_ack", int'(div_ack), 0);

    push_per(16, 16); push_per(16, 16); push_per(16, 16);
    @(posedge clk_in); #1;
    reset = 1'b1;
    cycles(40);

    chk("left_periods", per_q.size(), 0);
    chk("left_acks", ack_q.size(), 0);
    chk("left_errs", err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
